// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: multi-cycle WIDTH-bit add/subtract unit. One nibble of each operand goes
// through a 4-bit ripple adder per cycle, least-significant nibble first. Each nibble's carry is
// registered and becomes the next nibble's carry-in.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_in_valid        operand set valid
//   o_in_ready        unit idle and able to accept operands
//   i_a, i_b          operands
//   i_cin             carry-in for add (ignored for subtract)
//   i_sub             0: a+b+cin, 1: a-b
//   o_out_valid       result valid
//   i_out_ready       consumer accepts the result
//   o_res             result
//   o_cout            carry out of the MSB; for subtract, 1 means no borrow
//   o_ovf             signed two's-complement overflow
//   o_zero            result is zero
//   o_busy            unit is not idle
module nibble_serial_alu #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned NNIB = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_busy
);

  localparam int unsigned STEP_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NNIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_alu: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_op_a, r_op_b, r_res;
  logic [STEP_W-1:0]  r_step;
  logic               r_carry, r_cout, r_ovf, r_zero;

  logic [3:0]         w_nib_a, w_nib_b;
  logic [4:0]         w_sum;
  logic [WIDTH-1:0]   w_res_next;
  logic               w_last;

  // 4-bit ripple adder stage plus the result word as it will look after this edge.
  always_comb begin
    w_nib_a    = r_op_a[4*r_step +: 4];
    w_nib_b    = r_op_b[4*r_step +: 4];
    w_sum      = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'b0, r_carry};
    w_res_next = r_res;
    w_res_next[4*r_step +: 4] = w_sum[3:0];
    w_last     = (r_step == LAST_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_in_valid)  w_state_next = StRun;
      StRun:   if (w_last)      w_state_next = StDone;
      StDone:  if (i_out_ready) w_state_next = StIdle;
      default:                  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_step  <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            // Subtract as a + ~b + 1.
            r_op_a  <= i_a;
            r_op_b  <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_step  <= '0;
          end
        end
        StRun: begin
          r_res   <= w_res_next;
          r_carry <= w_sum[4];
          r_step  <= r_step + STEP_W'(1);
          if (w_last) begin
            r_cout <= w_sum[4];
            r_ovf  <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                      (w_res_next[WIDTH-1] != r_op_a[WIDTH-1]);
            r_zero <= (w_res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_busy      = (r_state != StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_res       = r_res;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Scoreboard bench for nibble_serial_alu (WIDTH=16): directed operations push hand-computed
// results into a queue; a monitor pops and compares on every out_valid/out_ready handshake.
module tb_nibble_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid, i_cin, i_sub, i_out_ready;
  logic [15:0] i_a, i_b;
  logic        o_in_ready, o_out_valid, o_cout, o_ovf, o_zero, o_busy;
  logic [15:0] o_res;

  nibble_serial_alu #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_cin       (i_cin),
    .i_sub       (i_sub),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_res       (o_res),
    .o_cout      (o_cout),
    .o_ovf       (o_ovf),
    .o_zero      (o_zero),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res %0h expected no result", o_res);
      end else begin
        mon_e = q.pop_front();
        chk("sb_res",  o_res,        mon_e.res);
        chk("sb_cout", 16'(o_cout),  16'(mon_e.c));
        chk("sb_ovf",  16'(o_ovf),   16'(mon_e.o));
        chk("sb_zero", 16'(o_zero),  16'(mon_e.z));
      end
    end
  end

  // Present an operand set, wait for acceptance, optionally record the expected result.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                       input logic [15:0] er, input logic ec, input logic eo, input logic ez,
                       input bit push);
    bit ok = 1'b0;
    i_a = a; i_b = b; i_cin = c; i_sub = s; i_in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    if (push) q.push_back('{res: er, c: ec, o: eo, z: ez});
    #1 i_in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got out_valid 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_in_ready) break;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; i_in_valid = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0;
    i_out_ready = 1'b1;
    #2;
    chk("rst_in_ready",  16'(o_in_ready),  16'd1);
    chk("rst_out_valid", 16'(o_out_valid), 16'd0);
    chk("rst_busy",      16'(o_busy),      16'd0);
    chk("rst_res",       o_res,            16'h0000);
    chk("rst_flags",     16'({o_cout, o_ovf, o_zero}), 16'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: simple adds and 4-cycle latency
    issue(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("latency_n%0d", k), 16'(o_out_valid), (k == 5) ? 16'd1 : 16'd0);
    end
    issue(16'h0003, 16'h0002, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2: full carry ripple
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // 3: signed overflow, add and subtract
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);

    // 4: subtract with borrow and equal operands; cin ignored
    issue(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // 5: backpressure and ignored in_valid while busy
    wait_idle();
    i_out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);
    i_a = 16'hFFFF; i_b = 16'hFFFF; i_cin = 1'b1; i_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("run_in_ready", 16'(o_in_ready), 16'd0);
    end
    wait_valid();
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid",    16'(o_out_valid), 16'd1);
      chk("hold_res",      o_res,            16'h3333);
      chk("hold_flags",    16'({o_cout, o_ovf, o_zero}), 16'd0);
      chk("hold_in_ready", 16'(o_in_ready),  16'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 i_in_valid = 1'b0; i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_in_ready",  16'(o_in_ready),  16'd1);
    chk("post_hs_out_valid", 16'(o_out_valid), 16'd0);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: asynchronous reset during RUN step 2
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 16'(o_out_valid), 16'd0);
    chk("abort_res",       o_res,            16'h0000);
    chk("abort_busy",      16'(o_busy),      16'd0);
    chk("abort_in_ready",  16'(o_in_ready),  16'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("queue_drained", 16'(q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_alu.md
Name: nibble_serial_alu

Overview:
- Multi-cycle WIDTH-bit add/subtract unit built around the team's 4-bit ripple adder (ADD_4bit: cin, a, b → res, cout).
- Sits directly upstream of ADD_4bit and feeds it one nibble of each operand per cycle, least-significant nibble first.
- Registers each nibble's cout and uses it as the next nibble's cin.
- Handshakes with the ALU front end (valid/ready in, valid/ready out) and returns the full result plus carry, overflow and zero flags.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and at least 8.
- NNIB, WIDTH/4: derived nibble count; not overridden by the instantiator.

Ports:
- clk  input  1  single clock; rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  unit can accept an operand set.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored for subtract.
- sub  input  1  0 = A+B+cin, 1 = A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- res  output  WIDTH  result.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  res == 0.
- busy  output  1  state is not IDLE.

Behaviour:
- States are IDLE, RUN and DONE. Reset (rst_n low, asynchronous) forces the following immediately, independent of clk:
  - state=IDLE; res=0, cout=0, ovf=0, zero=0, out_valid=0, busy=0; internal step counter, carry and operand registers = 0.
- in_ready = (state==IDLE), combinational. It is 1 while in reset.
- IDLE:
  - On a clk edge with in_valid && in_ready, latch a into opA.
  - Latch opB = sub ? ~b : b.
  - Latch carry = sub ? 1 : cin.
  - Set step=0 and go to RUN.
  - Operands need only be stable at the accept edge.
- RUN:
  - Each cycle drives the ADD_4bit instance with opA[4*step+:4], opB[4*step+:4] and carry.
  - On the edge, write the sum into res[4*step+:4], set carry←ADD_4bit cout and increment step.
  - On the edge where step==NNIB−1:
    - cout←final carry.
    - ovf←(opA[MSB]==opB[MSB]) && (final res[MSB]!=opA[MSB]).
    - zero←(final res==0). Computed from the completed word including the nibble written this edge.
    - Go to DONE.
  - in_valid is ignored in RUN and DONE; no capture occurs and no operand register changes.
- DONE:
  - out_valid=1; res and the flags stay stable until out_ready is sampled high.
  - On an edge with out_ready: out_valid←0, go to IDLE. res and the flags keep their values until the next result overwrites them.
- Latency: out_valid rises NNIB cycles after the accept edge, i.e. 4 for WIDTH=16.
- Minimum issue interval is NNIB+2 cycles (one accept cycle in IDLE, NNIB in RUN, one in DONE with out_ready high).
- res nibbles above the current step hold the previous operation's value during RUN. Consumers only sample res when out_valid=1.
- Wrap-around:
  - Carry out of the MSB nibble is reported in cout and never fed back.
  - Arithmetic is modulo 2^WIDTH.
- Reset mid-operation aborts the operation with no partial output; the next accepted operation is computed from scratch.
- out_ready high outside DONE has no effect.

Test Plan:
1. add 0x0001+0x0002 cin=0 → res=0x0003, cout=0, ovf=0, zero=0. out_valid is high exactly 4 cycles after the accept edge. Then 0x0003+0x0002 cin=1 → res=0x0006.
2. add 0xFFFF+0x0001 cin=0 → res=0x0000, cout=1, zero=1, ovf=0. This checks that the carry ripples through all 4 nibble steps.
3. add 0x7FFF+0x0001 → res=0x8000, ovf=1, cout=0. Then sub 0x8000−0x0001 → res=0x7FFF, ovf=1, cout=1.
4. sub 0x0003−0x0005 → res=0xFFFE, cout=0 (borrow), ovf=0. sub 0x1234−0x1234 → res=0x0000, zero=1, cout=1. For both, cin=1 is driven and ignored.
5. Backpressure:
   - Hold out_ready=0 for 3 cycles in DONE → out_valid, res and flags remain stable.
   - in_valid with new operands during RUN/DONE → ignored; in_ready stays 0.
   - After the out_ready handshake, in_ready=1 the next cycle and the new op is accepted.
6. Pull rst_n low between clk edges during RUN step 2 → out_valid=0, res=0, busy=0 and in_ready=1 immediately. After release, 0x00F0+0x0010 → res=0x0100.
